// File: rtl/alu_mdu_seq.sv
// ---------------------------------------------------------------------------
// alu_mdu_seq -- XLEN-bit RISC-V execute unit: base integer ALU plus
// iterative M-extension multiply/divide behind a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any iterative op)
//   in_valid   operation request
//   in_ready   unit accepts an operation on this edge
//   a, b       operands (rs1, rs2/imm), captured at acceptance
//   op         5-bit operation code (0..17 legal, 18..31 illegal)
//   out_valid  result/zero/illegal valid, held until out_ready
//   out_ready  consumer accepts the result
//   result     operation result
//   zero       registered result == 0 (1 for illegal ops)
//   illegal    op not supported
//   busy       iterative multiply/divide in progress
//
// Build option:
//   ALU_MDU_DIV_EN  when defined, ops 14..17 (DIV/DIVU/REM/REMU) use a
//                   restoring divider; when undefined the divider is
//                   removed and those ops report illegal.
// ---------------------------------------------------------------------------
module alu_mdu_seq #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_AND    = 5'd2;
   localparam logic [4:0] OP_OR     = 5'd3;
   localparam logic [4:0] OP_XOR    = 5'd4;
   localparam logic [4:0] OP_SLL    = 5'd5;
   localparam logic [4:0] OP_SRL    = 5'd6;
   localparam logic [4:0] OP_SRA    = 5'd7;
   localparam logic [4:0] OP_SLT    = 5'd8;
   localparam logic [4:0] OP_SLTU   = 5'd9;
   localparam logic [4:0] OP_MUL    = 5'd10;
   localparam logic [4:0] OP_MULH   = 5'd11;
   localparam logic [4:0] OP_MULHU  = 5'd13;
`ifdef ALU_MDU_DIV_EN
   localparam logic [4:0] OP_DIV    = 5'd14;
   localparam logic [4:0] OP_DIVU   = 5'd15;
   localparam logic [4:0] OP_REM    = 5'd16;
   localparam logic [4:0] OP_REMU   = 5'd17;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   // Control state
   state_t            state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              zero_q, zero_d;
   logic              illegal_q, illegal_d;
   logic              busy_q, busy_d;
   logic [SHW-1:0]    cnt_q, cnt_d;

   // Iterative datapath: opb holds the multiplicand / divisor magnitude,
   // acc holds {product high, multiplier} or {remainder, dividend/quotient}.
   logic [4:0]        op_q, op_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic              sa_q, sa_d;
   logic              sb_q, sb_d;

   logic              accept;
   logic              wr_en;
   logic [XLEN-1:0]   wr_val;
   logic              wr_ill;

   // Two's-complement negate when neg is set (magnitude <-> signed value).
   function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v,
                                                 input logic            neg);
      return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] apply_sign_wide(input logic [2*XLEN-1:0] v,
                                                        input logic              neg);
      return neg ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
   endfunction

   function automatic logic [XLEN-1:0] alu_calc(input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y,
                                               input logic [4:0]      o);
      logic signed [XLEN-1:0] xs;
      logic signed [XLEN-1:0] ys;
      logic [SHW-1:0]         sh;
      xs = x;
      ys = y;
      sh = y[SHW-1:0];
      case (o)
         OP_ADD:  return x + y;
         OP_SUB:  return x - y;
         OP_AND:  return x & y;
         OP_OR:   return x | y;
         OP_XOR:  return x ^ y;
         OP_SLL:  return x << sh;
         OP_SRL:  return x >> sh;
         OP_SRA:  return xs >>> sh;
         OP_SLT:  return {{(XLEN-1){1'b0}}, (xs < ys)};
         OP_SLTU: return {{(XLEN-1){1'b0}}, (x < y)};
         default: return '0;
      endcase
   endfunction

   // One shift-add step: add multiplicand when the current multiplier bit
   // is set, then shift the whole accumulator right by one.
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_acc;
   logic [2*XLEN-1:0] mul_fix;

   assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : '0)};
   assign mul_acc = {mul_sum, acc_q[XLEN-1:1]};
   assign mul_fix = apply_sign_wide(mul_acc, sa_q ^ sb_q);

`ifdef ALU_MDU_DIV_EN
   // One restoring step: shift the next dividend bit into the partial
   // remainder and subtract the divisor if it fits. The top bit of the
   // XLEN+1-bit difference is the borrow.
   logic [XLEN:0]     div_rs;
   logic [XLEN:0]     div_diff;
   logic              div_ge;
   logic [2*XLEN-1:0] div_acc;
   logic [XLEN-1:0]   div_q_fix;
   logic [XLEN-1:0]   div_r_fix;
   logic              div_signed;
   logic              div_is_rem;

   assign div_rs     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign div_diff   = div_rs - {1'b0, opb_q};
   assign div_ge     = ~div_diff[XLEN];
   assign div_acc    = {(div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ge};
   assign div_q_fix  = apply_sign(div_acc[XLEN-1:0], sa_q ^ sb_q);
   assign div_r_fix  = apply_sign(div_acc[2*XLEN-1:XLEN], sa_q);
   assign div_signed = (op == OP_DIV) || (op == OP_REM);
   assign div_is_rem = (op == OP_REM) || (op == OP_REMU);
`endif

   assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
      busy_d      = busy_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      opb_d       = opb_q;
      acc_d       = acc_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      wr_en       = 1'b0;
      wr_val      = '0;
      wr_ill      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
            end
            if (accept) begin
               op_d = op;
               if (op <= OP_SLTU) begin
                  wr_en  = 1'b1;
                  wr_val = alu_calc(a, b, op);
               end else if (op <= OP_MULHU) begin
                  // MUL low half is sign-agnostic; treating it as s x s is fine.
                  state_d = ST_MUL;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
                  sa_d    = (op != OP_MULHU) && a[XLEN-1];
                  sb_d    = ((op == OP_MUL) || (op == OP_MULH)) && b[XLEN-1];
                  opb_d   = apply_sign(a, sa_d);
                  acc_d   = {{XLEN{1'b0}}, apply_sign(b, sb_d)};
               end
`ifdef ALU_MDU_DIV_EN
               else if (op <= OP_REMU) begin
                  if (b == '0) begin
                     wr_en  = 1'b1;
                     wr_val = div_is_rem ? a : '1;
                  end else if (div_signed && (a == MOST_NEG) && (b == '1)) begin
                     wr_en  = 1'b1;
                     wr_val = div_is_rem ? '0 : a;
                  end else begin
                     state_d = ST_DIV;
                     busy_d  = 1'b1;
                     cnt_d   = '0;
                     sa_d    = div_signed && a[XLEN-1];
                     sb_d    = div_signed && b[XLEN-1];
                     opb_d   = apply_sign(b, sb_d);
                     acc_d   = {{XLEN{1'b0}}, apply_sign(a, sa_d)};
                  end
               end
`else
               // Without the divider, ops 14..17 take the illegal path below.
`endif
               else begin
                  wr_en  = 1'b1;
                  wr_ill = 1'b1;
               end
            end
         end

         ST_MUL: begin
            acc_d = mul_acc;
            cnt_d = cnt_q + SHW'(1);
            // Last step's sum is used directly so the result lands on edge N+XLEN.
            if (cnt_q == CNT_LAST) begin
               wr_en   = 1'b1;
               wr_val  = (op_q == OP_MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end
         end

`ifdef ALU_MDU_DIV_EN
         ST_DIV: begin
            acc_d = div_acc;
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == CNT_LAST) begin
               wr_en   = 1'b1;
               wr_val  = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? div_q_fix : div_r_fix;
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase

      if (wr_en) begin
         result_d    = wr_val;
         zero_d      = (wr_val == '0);
         illegal_d   = wr_ill;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      op_q  <= op_d;
      opb_q <= opb_d;
      acc_q <= acc_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      if (rst) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_mdu_seq -- self-checking bench for alu_mdu_seq (XLEN=64).
// Directed cases plus randomized operations, each checked against a
// behavioural model using plain SystemVerilog arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_mdu_seq;

   localparam int XLEN = 64;
   localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic [4:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        zero;
   logic        illegal;
   logic        busy;

   int total = 0;
   int bad   = 0;

   alu_mdu_seq #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: result, illegal flag and number of edges after acceptance
   // before out_valid appears (0 = visible right after the acceptance edge).
   function automatic void ref_op(input logic [63:0] x, input logic [63:0] y,
                                  input logic [4:0] o, output logic [63:0] r,
                                  output logic il, output int edges);
      logic [127:0] p;
      longint       sx;
      longint       sy;
      sx    = x;
      sy    = y;
      r     = '0;
      il    = 1'b0;
      edges = 0;
      p     = '0;
      case (o)
         5'd0:  r = x + y;
         5'd1:  r = x - y;
         5'd2:  r = x & y;
         5'd3:  r = x | y;
         5'd4:  r = x ^ y;
         5'd5:  r = x << y[5:0];
         5'd6:  r = x >> y[5:0];
         5'd7:  r = sx >>> y[5:0];
         5'd8:  r = (sx < sy) ? 64'd1 : 64'd0;
         5'd9:  r = (x < y) ? 64'd1 : 64'd0;
         5'd10: begin r = x * y; edges = XLEN; end
         5'd11: begin
            p = {{64{x[63]}}, x} * {{64{y[63]}}, y};
            r = p[127:64]; edges = XLEN;
         end
         5'd12: begin
            p = {{64{x[63]}}, x} * {64'd0, y};
            r = p[127:64]; edges = XLEN;
         end
         5'd13: begin
            p = {64'd0, x} * {64'd0, y};
            r = p[127:64]; edges = XLEN;
         end
`ifdef ALU_MDU_DIV_EN
         5'd14: begin
            if (y == 64'd0) r = ONES64;
            else if (x == MIN64 && y == ONES64) r = x;
            else begin r = sx / sy; edges = XLEN; end
         end
         5'd15: begin
            if (y == 64'd0) r = ONES64;
            else begin r = x / y; edges = XLEN; end
         end
         5'd16: begin
            if (y == 64'd0) r = x;
            else if (x == MIN64 && y == ONES64) r = 64'd0;
            else begin r = sx % sy; edges = XLEN; end
         end
         5'd17: begin
            if (y == 64'd0) r = x;
            else begin r = x % y; edges = XLEN; end
         end
`endif
         default: il = 1'b1;
      endcase
   endfunction

   // Issue one op, check latency, busy/in_ready while iterating, result,
   // zero, illegal, optional hold under backpressure, and the valid drop.
   task automatic run_op(input string tag, input logic [63:0] x, input logic [63:0] y,
                         input logic [4:0] o, input int hold);
      logic [63:0] er;
      logic        el;
      int          elat;
      int          n;
      int          lat;
      logic        seen;
      ref_op(x, y, o, er, el, elat);
      @(negedge clk);
      out_ready = (hold == 0);
      a         = x;
      b         = y;
      op        = o;
      in_valid  = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = {$urandom(), $urandom()};
      b        = {$urandom(), $urandom()};
      op       = 5'($urandom_range(0, 31));
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
         if (i == 0 && elat > 0) begin
            check({tag, ".busy"}, 64'(busy), 64'd1);
            check({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
         end
         @(posedge clk);
         lat++;
      end
      check({tag, ".seen"}, 64'(seen), 64'd1);
      check({tag, ".latency"}, 64'(lat), 64'(elat));
      check({tag, ".result"}, result, er);
      check({tag, ".zero"}, 64'(zero), 64'(er == 64'd0));
      check({tag, ".illegal"}, 64'(illegal), 64'(el));
      check({tag, ".busy_done"}, 64'(busy), 64'd0);
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
         check({tag, ".hold_result"}, result, er);
         check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
         out_ready = 1'b1;
      end
      @(negedge clk);
      check({tag, ".drop"}, 64'(out_valid), 64'd0);
   endtask

   function automatic logic [63:0] rnd_val();
      logic [63:0] v;
      case ($urandom_range(0, 5))
         0: v = 64'd0;
         1: v = ONES64;
         2: v = MIN64;
         3: v = {32'd0, 32'($urandom_range(0, 32))} - 64'd16;
         default: v = {$urandom(), $urandom()};
      endcase
      return v;
   endfunction

   initial begin
      logic [63:0] sx[4];
      logic [63:0] sy[4];
      logic [63:0] er;
      logic        el;
      int          elat;
      logic        anyv;
      logic [4:0]  ro;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      op        = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.result", result, 64'd0);
      check("rst.zero", 64'(zero), 64'd0);
      check("rst.illegal", 64'(illegal), 64'd0);
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.in_ready", 64'(in_ready), 64'd1);

      // Directed cases
      run_op("add_zero", 64'd5, -64'sd5, 5'd0, 0);
      run_op("sra", MIN64, 64'h43, 5'd7, 0);
      run_op("sltu", 64'd1, ONES64, 5'd9, 0);
      run_op("slt", ONES64, 64'd1, 5'd8, 0);
      run_op("mul", -64'sd3, 64'd7, 5'd10, 0);
      run_op("mulhu", ONES64, ONES64, 5'd13, 0);
      run_op("mulh", -64'sd3, 64'd7, 5'd11, 0);
      run_op("mulhsu", ONES64, ONES64, 5'd12, 0);
      run_op("op25", 64'd123, 64'd456, 5'd25, 0);
`ifdef ALU_MDU_DIV_EN
      run_op("div", -64'sd7, 64'd2, 5'd14, 0);
      run_op("rem", -64'sd7, 64'd2, 5'd16, 0);
      run_op("divu_z", 64'd9, 64'd0, 5'd15, 0);
      run_op("remu_z", 64'd9, 64'd0, 5'd17, 0);
      run_op("div_ovf", MIN64, ONES64, 5'd14, 0);
      run_op("rem_ovf", MIN64, ONES64, 5'd16, 0);
`else
      run_op("div_off", -64'sd7, 64'd2, 5'd14, 0);
      run_op("remu_off", 64'd9, 64'd4, 5'd17, 0);
`endif

      // Reset in the middle of a multiply
      @(negedge clk);
      a = -64'sd3; b = 64'd7; op = 5'd10; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("rstmul.busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstmul.out_valid", 64'(out_valid), 64'd0);
      check("rstmul.busy", 64'(busy), 64'd0);
      check("rstmul.in_ready", 64'(in_ready), 64'd1);
      anyv = 1'b0;
      repeat (70) begin
         @(negedge clk);
         if (out_valid) anyv = 1'b1;
      end
      check("rstmul.no_result", 64'(anyv), 64'd0);

      // Backpressure then back-to-back stream
      run_op("add_hold", 64'd100, 64'd23, 5'd0, 5);
      @(negedge clk);
      out_ready = 1'b0;
      a = 64'd40; b = 64'd2; op = 5'd0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("bp.valid", 64'(out_valid), 64'd1);
         check("bp.result", result, 64'd42);
         check("bp.in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sx[k] = {$urandom(), $urandom()};
         sy[k] = {$urandom(), $urandom()};
      end
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a = sx[k]; b = sy[k]; op = 5'd0;
         @(posedge clk);
         #1;
         if (k == 3) in_valid = 1'b0;
         @(negedge clk);
         ref_op(sx[k], sy[k], 5'd0, er, el, elat);
         check("stream.valid", 64'(out_valid), 64'd1);
         check("stream.result", result, er);
      end
      @(negedge clk);
      check("stream.drop", 64'(out_valid), 64'd0);

      // Randomized operations
      for (int t = 0; t < 120; t++) begin
         if ($urandom_range(0, 9) < 4) ro = 5'($urandom_range(10, 17));
         else ro = 5'($urandom_range(0, 31));
         run_op("rnd", rnd_val(), rnd_val(), ro,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised XLEN-bit execute unit for the single-cycle RISC-V datapath.
- Covers the full base integer ALU operation set, with registered outputs.
- Adds iterative M-extension multiply and divide on a valid/ready handshake, so the core can stall on long operations.
- Sits between decode/regfile read and writeback; one operation in flight at a time.

Parameters:
- XLEN, 64, operand/result width; power of two, 8..128.
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept an operation this cycle.
- a  in  XLEN  operand A (rs1).
- b  in  XLEN  operand B (rs2/imm).
- op  in  5  operation code.
- out_valid  out  1  result/zero/illegal valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result.
- zero  out  1  result == 0.
- illegal  out  1  op not supported.
- busy  out  1  iterative operation in progress.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, illegal=0, busy=0, iteration counter=0.
- Reset mid-operation aborts the operation; no result is produced.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is b[SHW-1:0].
  - 8 SLT, 9 SLTU (result 0/1, zero-extended).
  - 10 MUL (low XLEN), 11 MULH (s×s), 12 MULHSU (s×u), 13 MULHU (u×u).
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - 18..31 illegal: result=0, zero=1, illegal=1, 1-cycle latency.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted on an edge where in_valid && in_ready.
  - Operands and op are captured at acceptance; later input changes are ignored.
- Output hold: out_valid stays high with result, zero and illegal stable until an edge with out_ready=1. out_valid then drops, unless a new 1-cycle op is accepted on the same edge, in which case out_valid stays high with the new result (back-to-back, 1 op/cycle).
- States:
  - IDLE: ops 0..9 and illegal ops write the output registers at the acceptance edge (latency 1). Ops 10..17 go to MUL or DIV, busy=1, counter=0.
  - MUL: radix-2 shift-add on operand magnitudes, one bit per cycle, 2·XLEN-bit accumulator. After XLEN iterations, sign fix-up plus high/low select is applied and written to result in the same edge.
  - DIV: restoring division on magnitudes, one quotient bit per cycle. After XLEN iterations, quotient/remainder are selected with signs fixed (quotient negative iff signs differ; remainder takes the sign of the dividend).
  - MUL/DIV exit: result written, out_valid=1, busy=0, return to IDLE.
- Iterative latency: accepted at edge N, out_valid first high after edge N+XLEN.
- Divide special cases (latency 1, no iteration):
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a = most negative, b = −1): DIV gives a; REM gives 0.
- zero is always computed from the registered result; it is 1 for illegal ops.
- Arithmetic wraps modulo 2^XLEN; no overflow flag.

Optional Feature:
- ALU_MDU_DIV_EN
  - Defined: ops 14..17 implemented as above.
  - Undefined: the divider datapath is removed; ops 14..17 are treated as illegal (result=0, zero=1, illegal=1, latency 1). MUL ops are unaffected.

Test Plan:
- Reset, then ADD a=5, b=−5 → out_valid after 1 edge, result=0, zero=1, illegal=0. Assert rst during a MUL → out_valid=0, busy=0, in_ready=1 on the next cycle.
- SRA a=0x8000_0000_0000_0000, b=0x43 (shift 3) → result=0xF000_0000_0000_0000; SLTU a=1, b=−1 → result=1.
- MUL a=−3, b=7 → out_valid exactly 64 edges after acceptance, result=−21. MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → result=0xFFFF_FFFF_FFFF_FFFE. busy high throughout; in_ready=0.
- DIV a=−7, b=2 → result=−3; REM → −1. DIVU a=9, b=0 → all-ones after 1 edge. DIV a=0x8000_0000_0000_0000, b=−1 → result=a.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD → result stable, in_ready=0. Then stream 4 ADDs with out_ready=1 → 4 results on consecutive cycles.
- op=25 → illegal=1, zero=1. Without ALU_MDU_DIV_EN, op=14 → illegal=1 after 1 edge.
